// File: rtl/dcache_ctrl_pkg.sv
// Shared types for the LSQ<->dcache responder: bus commands, cache line payload, controller state.
// Also holds the address-split helpers.
package dcache_ctrl_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NUM_LINES = 32;
    localparam int unsigned IDX_W     = $clog2(NUM_LINES);
    localparam int unsigned OFS_W     = 3;
    localparam int unsigned CTAG_W    = XLEN - IDX_W - OFS_W;
    localparam int unsigned MTAG_W    = 4;
    localparam int unsigned DATA_W    = 64;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef struct packed {
        logic              valid;
        logic [CTAG_W-1:0] tag;
        logic [DATA_W-1:0] data;
    } DCACHE_LINE;

    typedef enum logic {
        DC_IDLE      = 1'b0,
        DC_WAIT_FILL = 1'b1
    } DCACHE_STATE;

    function automatic logic [IDX_W-1:0] addr_idx(input logic [XLEN-1:0] addr);
        return addr[IDX_W+OFS_W-1:OFS_W];
    endfunction

    function automatic logic [CTAG_W-1:0] addr_tag(input logic [XLEN-1:0] addr);
        return addr[XLEN-1:IDX_W+OFS_W];
    endfunction

endpackage

// File: rtl/dcache_mem.sv
// Direct-mapped line storage: one combinational read port, one synchronous write port.
// Reset clears only the valid bits; tag/data contents are don't-care until written.
module dcache_mem
    import dcache_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output DCACHE_LINE       rd_line,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  DCACHE_LINE       wr_line
);

    DCACHE_LINE mem_q [NUM_LINES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_LINES); i++) begin
                mem_q[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_line;
        end
    end

    assign rd_line = mem_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Responder end of the LSQ<->dcache interface: direct-mapped, write-through, no-write-allocate,
// with a single outstanding memory transaction. Responses to the LSQ are same-cycle combinational.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  BUS_COMMAND        dcache_command,
    input  logic [XLEN-1:0]   dcache_addr,
    input  logic [DATA_W-1:0] dcache_data,
    output logic [DATA_W-1:0] dcache_data_out,
    output logic              dcache_hit,
    output logic [MTAG_W-1:0] dcache_tag,
    output logic [MTAG_W-1:0] dcache_response,
    output BUS_COMMAND        proc2mem_command,
    output logic [XLEN-1:0]   proc2mem_addr,
    output logic [DATA_W-1:0] proc2mem_data,
    input  logic [MTAG_W-1:0] mem2proc_response,
    input  logic [DATA_W-1:0] mem2proc_data,
    input  logic [MTAG_W-1:0] mem2proc_tag
);

    DCACHE_STATE       state_q, state_d;
    logic [MTAG_W-1:0] pend_tag_q, pend_tag_d;
    logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
    logic [CTAG_W-1:0] pend_ctag_q, pend_ctag_d;

    DCACHE_LINE        rd_line;
    DCACHE_LINE        wr_line;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;

    logic [IDX_W-1:0]  req_idx;
    logic [CTAG_W-1:0] req_ctag;
    logic [XLEN-1:0]   req_line_addr;
    logic              hit_c;
    logic              fill_c;
    logic              unused_ofs;

    assign req_idx       = addr_idx(dcache_addr);
    assign req_ctag      = addr_tag(dcache_addr);
    assign req_line_addr = {dcache_addr[XLEN-1:OFS_W], OFS_W'(0)};
    assign unused_ofs    = ^dcache_addr[OFS_W-1:0];
    assign hit_c         = rd_line.valid && (rd_line.tag == req_ctag);
    assign fill_c        = (state_q == DC_WAIT_FILL) && (mem2proc_tag != '0)
                           && (mem2proc_tag == pend_tag_q);

    dcache_mem u_mem (
        .clk     (clk),
        .reset   (reset),
        .rd_idx  (req_idx),
        .rd_line (rd_line),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_line (wr_line)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DC_IDLE;
            pend_tag_q  <= '0;
            pend_idx_q  <= '0;
            pend_ctag_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_tag_q  <= pend_tag_d;
            pend_idx_q  <= pend_idx_d;
            pend_ctag_q <= pend_ctag_d;
        end
    end

    // Fill has priority over any same-cycle request; requests resume the cycle after the fill.
    always_comb begin
        state_d          = state_q;
        pend_tag_d       = pend_tag_q;
        pend_idx_d       = pend_idx_q;
        pend_ctag_d      = pend_ctag_q;
        dcache_data_out  = '0;
        dcache_hit       = 1'b0;
        dcache_tag       = '0;
        dcache_response  = '0;
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        wr_en            = 1'b0;
        wr_idx           = req_idx;
        wr_line          = '{valid: 1'b1, tag: req_ctag, data: dcache_data};

        if (!reset) begin
            if (fill_c) begin
                dcache_response = pend_tag_q;
                dcache_data_out = mem2proc_data;
                wr_en           = 1'b1;
                wr_idx          = pend_idx_q;
                wr_line         = '{valid: 1'b1, tag: pend_ctag_q, data: mem2proc_data};
                pend_tag_d      = '0;
                state_d         = DC_IDLE;
            end else if (dcache_command == BUS_LOAD) begin
                if (hit_c) begin
                    dcache_hit      = 1'b1;
                    dcache_data_out = rd_line.data;
                end else if (state_q == DC_IDLE) begin
                    proc2mem_command = BUS_LOAD;
                    proc2mem_addr    = req_line_addr;
                    dcache_tag       = mem2proc_response;
                    if (mem2proc_response != '0) begin
                        pend_tag_d  = mem2proc_response;
                        pend_idx_d  = req_idx;
                        pend_ctag_d = req_ctag;
                        state_d     = DC_WAIT_FILL;
                    end
                end
            end else if (dcache_command == BUS_STORE && state_q == DC_IDLE) begin
                proc2mem_command = BUS_STORE;
                proc2mem_addr    = req_line_addr;
                proc2mem_data    = dcache_data;
                dcache_tag       = mem2proc_response;
                wr_en            = (mem2proc_response != '0) && hit_c;
            end
        end
    end

endmodule
